// File: rtl/prog_counter_if.sv
// Next-PC / PC bus between the next-address logic and the program counter.
// The master drives the load request and the slave returns the current address.
interface prog_counter_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] adrs_in;
    logic              en_pc;
    logic [ADDR_W-1:0] adrs_out;

    modport master (
        output adrs_in,
        output en_pc,
        input  adrs_out
    );

    modport slave (
        input  adrs_in,
        input  en_pc,
        output adrs_out
    );
endinterface

// File: rtl/prog_counter.sv
// Program counter register with synchronous active-high clear and a load enable.
// Define PC_AUTOINC_EN to make the counter increment (wrapping) whenever no load is requested.
module prog_counter #(
    parameter int                ADDR_W     = 8,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  logic             clk,
    input  logic             clr,
    prog_counter_if.slave    bus
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    // Load has priority over the optional increment; without the macro the PC simply holds.
    always_comb begin
        pc_d = pc_q;
        if (bus.en_pc) begin
            pc_d = bus.adrs_in;
        end
`ifdef PC_AUTOINC_EN
        else begin
            pc_d = pc_q + ADDR_W'(1);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            pc_q <= RESET_ADDR;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign bus.adrs_out = pc_q;

endmodule

// File: tb/tb_prog_counter.sv
// Self-checking bench for prog_counter: directed vector table, mid-cycle reset sequences,
// and randomized traffic against a reference model (honours PC_AUTOINC_EN).
module tb_prog_counter;

`ifdef PC_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    localparam logic [7:0] RESET_ADDR = 8'h00;

    typedef struct {
        logic       clr;
        logic       en_pc;
        logic [7:0] adrs_in;
        logic [7:0] expected;
    } vec_t;

    logic tstclk;
    logic clr;
    int   total;
    int   bad;
    vec_t vecs[$];
    logic [7:0] model_pc;

    prog_counter_if #(.ADDR_W(8)) bus ();

    prog_counter #(
        .ADDR_W    (8),
        .RESET_ADDR(RESET_ADDR)
    ) dut (
        .clk(tstclk),
        .clr(clr),
        .bus(bus)
    );

    initial begin
        tstclk = 1'b0;
        forever #5 tstclk = ~tstclk;
    end

    // Drive one edge worth of inputs, then settle just past the rising edge.
    task automatic applyStimulus(input logic c, input logic e, input logic [7:0] a);
        clr         = c;
        bus.en_pc   = e;
        bus.adrs_in = a;
        @(posedge tstclk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] expected);
        total++;
        if (bus.adrs_out !== expected) begin
            bad++;
            $display("[TB] FAIL %s: adrs_out=%h expected=%h", name, bus.adrs_out, expected);
        end
    endtask

    function automatic void addVec(input logic c, input logic e, input logic [7:0] a,
                                   input logic [7:0] x);
        vec_t v;
        v.clr      = c;
        v.en_pc    = e;
        v.adrs_in  = a;
        v.expected = x;
        vecs.push_back(v);
    endfunction

    // Spec rules in plain arithmetic: reset wins, then load, then hold or wrapping increment.
    function automatic logic [7:0] nextPc(input logic [7:0] cur, input logic c, input logic e,
                                          input logic [7:0] a);
        int n;
        if (c) return RESET_ADDR;
        if (e) return a;
        if (AUTOINC) begin
            n = (int'(cur) + 1) % 256;
            return 8'(n);
        end
        return cur;
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        total       = 0;
        bad         = 0;
        clr         = 1'b0;
        bus.en_pc   = 1'b0;
        bus.adrs_in = 8'h00;

        // Reset held with a load pending
        addVec(1, 1, 8'h55, 8'h00);
        addVec(1, 1, 8'h55, 8'h00);
        // Sequential load, then a steady load of the same value
        for (int i = 1; i <= 5; i++) addVec(0, 1, 8'(i), 8'(i));
        for (int i = 0; i < 5; i++) addVec(0, 1, 8'h05, 8'h05);
        // Hold (or count up) while adrs_in toggles
        addVec(0, 1, 8'h3C, 8'h3C);
        addVec(0, 0, 8'hA0, AUTOINC ? 8'h3D : 8'h3C);
        addVec(0, 0, 8'h0F, AUTOINC ? 8'h3E : 8'h3C);
        addVec(0, 0, 8'hA0, AUTOINC ? 8'h3F : 8'h3C);
        addVec(0, 0, 8'h0F, AUTOINC ? 8'h40 : 8'h3C);
        // Reset priority in the middle of a run
        addVec(0, 1, 8'h04, 8'h04);
        addVec(1, 1, 8'h77, 8'h00);
        addVec(0, 1, 8'h77, 8'h77);
        // Boundary values
        addVec(0, 1, 8'hFF, 8'hFF);
        addVec(0, 1, 8'h00, 8'h00);
        // Wrap-around of the increment, then load priority
        addVec(0, 1, 8'hFE, 8'hFE);
        addVec(0, 0, 8'h12, AUTOINC ? 8'hFF : 8'hFE);
        addVec(0, 0, 8'h34, AUTOINC ? 8'h00 : 8'hFE);
        addVec(0, 0, 8'h56, AUTOINC ? 8'h01 : 8'hFE);
        addVec(0, 1, 8'h40, 8'h40);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].clr, vecs[i].en_pc, vecs[i].adrs_in);
            checkOutput($sformatf("vec[%0d]", i), vecs[i].expected);
        end

        // clr raised mid-cycle must wait for the edge; adrs_in has no path to the output
        applyStimulus(0, 1, 8'h5A);
        checkOutput("load_5a", 8'h5A);
        clr         = 1'b1;
        bus.adrs_in = 8'hC3;
        #2;
        checkOutput("clr_mid_cycle", 8'h5A);
        @(posedge tstclk);
        #1;
        checkOutput("clr_at_edge", 8'h00);
        clr         = 1'b0;
        bus.adrs_in = 8'h21;
        #2;
        checkOutput("clr_release_mid_cycle", 8'h00);
        @(posedge tstclk);
        #1;
        checkOutput("load_after_release", 8'h21);
        bus.en_pc   = 1'b0;
        bus.adrs_in = 8'h99;
        #2;
        checkOutput("idle_input_change", 8'h21);

        // Randomized traffic against the reference model
        applyStimulus(1, 0, 8'h00);
        model_pc = RESET_ADDR;
        checkOutput("rand_reset", model_pc);
        for (int i = 0; i < 300; i++) begin
            logic       c;
            logic       e;
            logic [7:0] a;
            c = ($urandom_range(0, 15) == 0);
            e = $urandom_range(0, 1) == 1;
            a = 8'($urandom_range(0, 255));
            applyStimulus(c, e, a);
            model_pc = nextPc(model_pc, c, e, a);
            checkOutput($sformatf("rand[%0d]", i), model_pc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
